dot_accum: RTL and testbench

DOT_ACCUM -- requirements
Module: dot_accum

---
 rtl/mult_pkg.sv | 18 +
 rtl/beat_counter.sv | 33 +++
 rtl/dot_accum.sv | 93 +++++++++
 tb/tb_dot_accum.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the multiply/accumulate datapath: product width,
// accumulator FSM states and the signed-add overflow rule.
package mult_pkg;

  localparam int unsigned PROD_W = 64;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  // Two's-complement add overflows when both operands share a sign that the result lacks.
  function automatic logic signed_add_ovf(input logic a_sign, input logic b_sign,
                                          input logic r_sign);
    return (a_sign == b_sign) && (r_sign != a_sign);
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Beat counter for the dot-product accumulator; synchronous clear wins over enable.
module beat_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dot_accum.sv
// Accumulates LEN signed 64-bit products into a wrapping ACC_W-bit sum, then
// holds the result (with a sticky overflow flag) until downstream takes it.
module dot_accum
  import mult_pkg::*;
#(
  parameter int unsigned LEN   = 4,
  parameter int unsigned ACC_W = 72
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic [PROD_W-1:0] prod,
  input  logic              prod_vld,
  output logic              prod_rdy,
  input  logic              flush,
  output logic [ACC_W-1:0]  acc,
  output logic              acc_vld,
  input  logic              acc_rdy,
  output logic              ovf
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);

  state_e           state_q;
  logic [ACC_W-1:0] sum_q;
  logic             ovf_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum_add;
  logic [CNT_W-1:0] count;
  logic             accept;
  logic             consume;
  logic             add_ovf;
  logic             last_beat;
  logic             close;

  // Handshake flags come only from the registered state, never from inputs.
  assign prod_rdy = (state_q == ACCUM);
  assign acc_vld  = (state_q == HOLD);

  assign accept  = prod_vld & prod_rdy;
  assign consume = acc_vld & acc_rdy;

  assign prod_ext = ACC_W'($signed(prod));
  assign sum_add  = sum_q + prod_ext;
  assign add_ovf  = signed_add_ovf(sum_q[ACC_W-1], prod_ext[ACC_W-1], sum_add[ACC_W-1]);

  assign last_beat = (count == CNT_W'(LEN - 1));

  // A flush with nothing accumulated and nothing arriving has no result to close.
  assign close = accept ? (last_beat | flush) : (flush & (count != '0));

  beat_counter #(
    .WIDTH (CNT_W)
  ) u_beat_counter (
    .CLK   (CLK),
    .rst_n (rst_n),
    .en    (accept),
    .clr   (consume),
    .count (count)
  );

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            sum_q <= sum_add;
            ovf_q <= ovf_q | add_ovf;
          end
          if (close) begin
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (acc_rdy) begin
            state_q <= ACCUM;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign acc = sum_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_dot_accum.sv
// Bench for dot_accum: a LEN=4/72-bit and a LEN=2/64-bit instance, directed cases
// plus random transactions checked against an exact-arithmetic reference.
module tb_dot_accum;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  logic [63:0]  prod_s [2];
  logic         pvld_s [2];
  logic         flush_s[2];
  logic         ardy_s [2];
  logic         rdy_s  [2];
  logic         vld_s  [2];
  logic         ovf_s  [2];
  logic [127:0] acc_s  [2];
  logic [71:0]  acc_a;
  logic [63:0]  acc_b;

  assign acc_s[0] = {56'b0, acc_a};
  assign acc_s[1] = {64'b0, acc_b};

  dot_accum #(.LEN(4), .ACC_W(72)) dut_a (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .prod     (prod_s[0]),
    .prod_vld (pvld_s[0]),
    .prod_rdy (rdy_s[0]),
    .flush    (flush_s[0]),
    .acc      (acc_a),
    .acc_vld  (vld_s[0]),
    .acc_rdy  (ardy_s[0]),
    .ovf      (ovf_s[0])
  );

  dot_accum #(.LEN(2), .ACC_W(64)) dut_b (
    .CLK      (CLK),
    .rst_n    (rst_n),
    .prod     (prod_s[1]),
    .prod_vld (pvld_s[1]),
    .prod_rdy (rdy_s[1]),
    .flush    (flush_s[1]),
    .acc      (acc_b),
    .acc_vld  (vld_s[1]),
    .acc_rdy  (ardy_s[1]),
    .ovf      (ovf_s[1])
  );

  int total = 0;
  int bad   = 0;

  logic [127:0] m_sum[2];
  bit           m_ovf[2];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact signed sum of the wrapped running value and the product;
  // overflow whenever that exact value falls outside the ACC_W-bit signed range.
  function automatic void model_add(input int sel, input logic [63:0] p);
    int w;
    logic signed [127:0] ps, exact, one, hi, lo;
    logic [127:0] mask;
    w     = (sel == 1) ? 64 : 72;
    one   = 128'sd1;
    ps    = m_sum[sel] << (128 - w);
    ps    = ps >>> (128 - w);
    exact = ps + $signed({{64{p[63]}}, p});
    hi    = (one <<< (w - 1)) - one;
    lo    = -(one <<< (w - 1));
    if (exact > hi || exact < lo) m_ovf[sel] = 1'b1;
    mask       = (128'd1 << w) - 128'd1;
    m_sum[sel] = exact & mask;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 2; i++) begin
      m_sum[i] = '0;
      m_ovf[i] = 1'b0;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the product is taken.
  task automatic send(input int sel, input logic [63:0] p, input bit fl);
    int n;
    bit rdy;
    prod_s[sel]  = p;
    pvld_s[sel]  = 1'b1;
    flush_s[sel] = fl;
    n = 0;
    do begin
      rdy = rdy_s[sel];
      @(posedge CLK);
      n++;
    end while (!rdy && n < 50);
    check("accept", rdy, 1);
    if (rdy) model_add(sel, p);
    @(negedge CLK);
    pvld_s[sel]  = 1'b0;
    flush_s[sel] = 1'b0;
  endtask

  task automatic flush_only(input int sel);
    flush_s[sel] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    flush_s[sel] = 1'b0;
  endtask

  task automatic collect(input int sel, input int hold);
    int n;
    n = 0;
    while (!vld_s[sel] && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("acc_vld", vld_s[sel], 1);
    check("acc", acc_s[sel], m_sum[sel]);
    check("ovf", ovf_s[sel], m_ovf[sel]);
    check("rdy_in_hold", rdy_s[sel], 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      check("hold_acc", acc_s[sel], m_sum[sel]);
    end
    ardy_s[sel] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ardy_s[sel] = 1'b0;
    check("vld_after_hs", vld_s[sel], 0);
    check("ovf_after_hs", ovf_s[sel], 0);
    check("acc_after_hs", acc_s[sel], 0);
    m_sum[sel] = '0;
    m_ovf[sel] = 1'b0;
  endtask

  function automatic logic [63:0] rand_prod();
    logic [63:0] p;
    case ($urandom_range(0, 3))
      0:       p = 64'(int'($urandom_range(0, 40)) - 20);
      1:       p = {$urandom, $urandom};
      2:       p = 64'h7fff_ffff_ffff_ff00 | 64'($urandom_range(0, 255));
      default: p = 64'h8000_0000_0000_0000 | 64'($urandom_range(0, 255));
    endcase
    return p;
  endfunction

  // mode 0: full LEN, 1: flush with the last product, 2: standalone flush after a partial.
  task automatic rand_txn(input int sel);
    int len_max, mode, n;
    len_max = (sel == 1) ? 2 : 4;
    mode    = $urandom_range(0, 2);
    case (mode)
      0:       n = len_max;
      1:       n = $urandom_range(1, len_max);
      default: n = $urandom_range(1, len_max - 1);
    endcase
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge CLK);
      send(sel, rand_prod(), (mode == 1) && (i == n - 1));
    end
    if (mode == 2) flush_only(sel);
    collect(sel, $urandom_range(0, 3));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      prod_s[i]  = '0;
      pvld_s[i]  = 1'b0;
      flush_s[i] = 1'b0;
      ardy_s[i]  = 1'b0;
    end
    model_clear();
    #1;
    check("rst_rdy", rdy_s[0], 1);
    check("rst_vld", vld_s[0], 0);
    check("rst_acc", acc_s[0], 0);
    check("rst_ovf", ovf_s[0], 0);
    @(negedge CLK);
    rst_n = 1'b1;

    // 1,2,3,4 back to back; result visible right after the 4th accept
    send(0, 64'd1, 0);
    send(0, 64'd2, 0);
    send(0, 64'd3, 0);
    check("vld_before_last", vld_s[0], 0);
    send(0, 64'd4, 0);
    check("vld_latency", vld_s[0], 1);
    check("sum10", acc_s[0], 128'd10);
    @(negedge CLK);
    check("rdy_hold_persist", rdy_s[0], 0);
    collect(0, 1);

    // sign extension: -5, 3, -2^63, -2^63
    send(0, -64'sd5, 0);
    send(0, 64'd3, 0);
    send(0, 64'h8000_0000_0000_0000, 0);
    send(0, 64'h8000_0000_0000_0000, 0);
    check("sext_const", acc_s[0], 128'hfe_ffff_ffff_ffff_fffe);
    collect(0, 0);

    // stall in HOLD with a product waiting
    send(0, 64'd5, 0);
    send(0, 64'd6, 0);
    send(0, 64'd7, 0);
    send(0, 64'd8, 0);
    prod_s[0] = 64'd99;
    pvld_s[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      check("stall_acc", acc_s[0], 128'd26);
      check("stall_rdy", rdy_s[0], 0);
    end
    ardy_s[0] = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ardy_s[0] = 1'b0;
    m_sum[0] = '0;
    m_ovf[0] = 1'b0;
    check("fresh_rdy", rdy_s[0], 1);
    check("fresh_acc", acc_s[0], 0);
    @(posedge CLK);
    @(negedge CLK);
    pvld_s[0] = 1'b0;
    model_add(0, 64'd99);
    check("fresh_first", acc_s[0], 128'd99);
    send(0, 64'd1, 0);
    send(0, 64'd1, 0);
    send(0, 64'd1, 0);
    check("fresh_sum", acc_s[0], 128'd102);
    collect(0, 0);

    // flush with the 2nd product, lone flush, flush after a partial
    send(0, 64'd7, 0);
    send(0, -64'sd2, 1);
    check("flush_sum", acc_s[0], 128'd5);
    collect(0, 0);
    flush_only(0);
    check("lone_flush0", vld_s[0], 0);
    @(negedge CLK);
    check("lone_flush1", vld_s[0], 0);
    send(0, 64'd3, 0);
    flush_only(0);
    check("partial_flush", acc_s[0], 128'd3);
    collect(0, 0);

    // 64-bit wrap with sticky overflow
    send(1, 64'h4000_0000_0000_0000, 0);
    send(1, 64'h4000_0000_0000_0000, 0);
    check("wrap_const", acc_s[1], 128'h8000_0000_0000_0000);
    check("wrap_ovf", ovf_s[1], 1);
    collect(1, 2);

    // async reset after 2 of 4 products
    send(0, 64'd10, 0);
    send(0, 64'd20, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc", acc_s[0], 0);
    check("arst_rdy", rdy_s[0], 1);
    check("arst_vld", vld_s[0], 0);
    @(negedge CLK);
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 4; i++) send(0, 64'd1, 0);
    check("after_rst_sum", acc_s[0], 128'd4);
    collect(0, 0);

    // async reset while a result with overflow is held
    send(1, 64'h7fff_ffff_ffff_ffff, 0);
    send(1, 64'd1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hold_vld", vld_s[1], 0);
    check("arst_hold_rdy", rdy_s[1], 1);
    check("arst_hold_ovf", ovf_s[1], 0);
    @(negedge CLK);
    rst_n = 1'b1;
    model_clear();

    for (int t = 0; t < 40; t++) rand_txn(0);
    for (int t = 0; t < 25; t++) rand_txn(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
